// File: rtl/button_debounce_monitor.sv
// button_debounce_monitor: synchronise, debounce and auto-repeat a bank of push-buttons
module button_debounce_monitor #(
    parameter int NUM_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter bit ACTIVE_LOW_INPUTS = 1'b1,
    parameter int REPEAT_DELAY      = 25000000,
    parameter int REPEAT_PERIOD     = 5000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic                   repeatEnable,
    output logic [NUM_BUTTONS-1:0] buttonPresses,
    output logic [NUM_BUTTONS-1:0] buttonReleases,
    output logic [NUM_BUTTONS-1:0] buttonHeld
);
    localparam int DW   = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = RMAX > 1 ? $clog2(RMAX) : 1;
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    logic [NUM_BUTTONS-1:0] norm, sync1, p;

    assign norm = ACTIVE_LOW_INPUTS ? ~buttons : buttons;

    // two-flop synchroniser on the polarity-normalised inputs (1 = pressed)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            p     <= '0;
        end else begin
            sync1 <= norm;
            p     <= sync1;
        end
    end

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
        state_t        state, state_n;
        logic [DW-1:0] cnt, cnt_n;
        logic [RW-1:0] rpt, rpt_n;
        logic          first, first_n;
        logic          press_n, rel_n;
        logic          press_q, rel_q, held_q;

        // next-state logic: debounce in the WAIT states, auto-repeat timing in HELD
        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            rpt_n   = rpt;
            first_n = first;
            press_n = 1'b0;
            rel_n   = 1'b0;
            case (state)
                IDLE:
                    if (p[g]) begin
                        state_n = PRESS_WAIT;
                        cnt_n   = '0;
                    end
                PRESS_WAIT:
                    if (!p[g]) state_n = IDLE;
                    else if (cnt == DEB_LAST) begin
                        state_n = HELD;
                        press_n = 1'b1;
                        rpt_n   = '0;
                        first_n = 1'b1;
                    end else cnt_n = cnt + 1'b1;
                HELD:
                    if (!p[g]) begin
                        state_n = RELEASE_WAIT;
                        cnt_n   = '0;
                    end else if (!repeatEnable) begin
                        rpt_n   = '0;
                        first_n = 1'b1;
                    end else if (rpt == (first ? DELAY_LAST : PERIOD_LAST)) begin
                        press_n = 1'b1;
                        rpt_n   = '0;
                        first_n = 1'b0;
                    end else rpt_n = rpt + 1'b1;
                RELEASE_WAIT:
                    if (p[g]) begin
                        state_n = HELD;
                        rpt_n   = '0;
                        first_n = 1'b1;
                    end else if (cnt == DEB_LAST) begin
                        state_n = IDLE;
                        rel_n   = 1'b1;
                    end else cnt_n = cnt + 1'b1;
                default: state_n = IDLE;
            endcase
        end

        // channel state and registered outputs
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state   <= IDLE;
                cnt     <= '0;
                rpt     <= '0;
                first   <= 1'b1;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                state   <= state_n;
                cnt     <= cnt_n;
                rpt     <= rpt_n;
                first   <= first_n;
                press_q <= press_n;
                rel_q   <= rel_n;
                held_q  <= (state_n == HELD) || (state_n == RELEASE_WAIT);
            end
        end

        assign buttonPresses[g]  = press_q;
        assign buttonReleases[g] = rel_q;
        assign buttonHeld[g]     = held_q;
    end
endmodule

// File: tb/tb_button_debounce_monitor.sv
// tb_button_debounce_monitor: directed and randomised checks against a run-length reference model
module tb_button_debounce_monitor;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] buttons = '1;
    logic         repeatEnable = 1'b0;
    logic [N-1:0] buttonPresses, buttonReleases, buttonHeld;

    int nvec = 0;
    int nerr = 0;

    logic [N-1:0] m_s1, m_p, m_held, m_press, m_rel;
    int           m_run[N];
    int           m_since[N];

    always #5 clock = ~clock;

    button_debounce_monitor #(
        .NUM_BUTTONS(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW_INPUTS(1'b1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clock), .reset(reset), .buttons(buttons), .repeatEnable(repeatEnable),
        .buttonPresses(buttonPresses), .buttonReleases(buttonReleases), .buttonHeld(buttonHeld)
    );

    task automatic model_clear();
        m_s1 = '0; m_p = '0; m_held = '0; m_press = '0; m_rel = '0;
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0;
            m_since[i] = 0;
        end
    endtask

    // a level change is accepted once the synchronised input has disagreed with the
    // accepted level for D+1 consecutive edges; repeats fall at RD, RD+RP, RD+2RP... edges
    task automatic model_edge();
        m_press = '0;
        m_rel = '0;
        for (int i = 0; i < N; i++) begin
            if (m_p[i] != m_held[i]) begin
                m_run[i]++;
                if (m_run[i] == D + 1) begin
                    m_held[i] = ~m_held[i];
                    m_press[i] = m_held[i];
                    m_rel[i] = ~m_held[i];
                    m_run[i] = 0;
                    m_since[i] = 0;
                end
            end else begin
                if (m_held[i]) begin
                    if (m_run[i] > 0 || !repeatEnable) m_since[i] = 0;
                    else begin
                        m_since[i]++;
                        if (m_since[i] >= RD && (m_since[i] - RD) % RP == 0) m_press[i] = 1'b1;
                    end
                end
                m_run[i] = 0;
            end
        end
        m_p = m_s1;
        m_s1 = ~buttons;
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_edge();
        #1;
    endtask

    task automatic settle(input int n);
        for (int j = 0; j < n; j++) begin
            tick();
            nvec++;
            if (buttonHeld !== m_held || buttonPresses !== m_press || buttonReleases !== m_rel) begin
                nerr++;
                $display("FAIL settle: got p=%b r=%b h=%b want p=%b r=%b h=%b",
                         buttonPresses, buttonReleases, buttonHeld, m_press, m_rel, m_held);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_clear();
        repeat (3) @(posedge clock);
        #1;
        nvec++;
        if ({buttonPresses, buttonReleases, buttonHeld} !== '0) begin
            nerr++;
            $display("FAIL reset_state: got p=%b r=%b h=%b want all 0", buttonPresses, buttonReleases, buttonHeld);
        end
        reset = 1'b1;
        settle(5);
    endtask

    task automatic test_clean_press();
        buttons = 4'b1110;
        for (int j = 1; j <= 10; j++) begin
            tick();
            nvec++;
            if (buttonPresses !== (j == 7 ? 4'b0001 : 4'b0000) || buttonReleases !== 4'b0000 ||
                buttonHeld !== (j >= 7 ? 4'b0001 : 4'b0000)) begin
                nerr++;
                $display("FAIL clean_press edge %0d: got p=%b r=%b h=%b want p=%b r=0000 h=%b", j,
                         buttonPresses, buttonReleases, buttonHeld, j == 7 ? 4'b0001 : 4'b0000,
                         j >= 7 ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_bounce();
        for (int j = 1; j <= 15; j++) begin
            buttons[1] = (j >= 4 && j <= 5);
            tick();
            nvec++;
            if (buttonPresses !== (j == 12 ? 4'b0010 : 4'b0000) || buttonReleases !== 4'b0000 ||
                buttonHeld[1] !== (j >= 12) || buttonHeld !== m_held) begin
                nerr++;
                $display("FAIL bounce edge %0d: got p=%b r=%b h=%b want p=%b model h=%b", j,
                         buttonPresses, buttonReleases, buttonHeld, j == 12 ? 4'b0010 : 4'b0000, m_held);
            end
        end
    endtask

    task automatic test_release();
        buttons[0] = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            nvec++;
            if (buttonReleases !== (j == 7 ? 4'b0001 : 4'b0000) || buttonPresses !== 4'b0000 ||
                buttonHeld !== (j >= 7 ? 4'b0010 : 4'b0011)) begin
                nerr++;
                $display("FAIL release edge %0d: got p=%b r=%b h=%b want r=%b p=0000 h=%b", j,
                         buttonPresses, buttonReleases, buttonHeld, j == 7 ? 4'b0001 : 4'b0000,
                         j >= 7 ? 4'b0010 : 4'b0011);
            end
        end
        buttons = '1;
        settle(10);
    endtask

    task automatic test_auto_repeat();
        for (int en = 1; en >= 0; en--) begin
            repeatEnable = en[0];
            buttons[2] = 1'b0;
            for (int j = 1; j <= 30; j++) begin
                logic [N-1:0] exp;
                tick();
                exp = ((j == 7) || (en == 1 && j >= 15 && (j - 15) % 3 == 0)) ? 4'b0100 : 4'b0000;
                nvec++;
                if (buttonPresses !== exp || buttonPresses !== m_press || buttonReleases !== 4'b0000) begin
                    nerr++;
                    $display("FAIL auto_repeat en=%0d edge %0d: got p=%b r=%b want p=%b model p=%b", en, j,
                             buttonPresses, buttonReleases, exp, m_press);
                end
            end
            buttons = '1;
            settle(10);
        end
    endtask

    task automatic test_simultaneous();
        for (int ph = 0; ph < 2; ph++) begin
            buttons = ph == 0 ? 4'b0000 : 4'b1111;
            for (int j = 1; j <= 9; j++) begin
                tick();
                nvec++;
                if ((ph == 0 ? buttonPresses : buttonReleases) !== (j == 7 ? 4'b1111 : 4'b0000) ||
                    (ph == 0 ? buttonReleases : buttonPresses) !== 4'b0000 || buttonHeld !== m_held) begin
                    nerr++;
                    $display("FAIL simultaneous ph=%0d edge %0d: got p=%b r=%b h=%b want pulse %b on %s", ph, j,
                             buttonPresses, buttonReleases, buttonHeld, j == 7 ? 4'b1111 : 4'b0000,
                             ph == 0 ? "press" : "release");
                end
            end
        end
    endtask

    task automatic test_reset_mid_held();
        buttons = 4'b0111;
        settle(9);
        nvec++;
        if (buttonHeld !== 4'b1000) begin
            nerr++;
            $display("FAIL reset_mid_held pre: got h=%b want 1000", buttonHeld);
        end
        reset = 1'b0;
        model_clear();
        #1;
        nvec++;
        if ({buttonPresses, buttonReleases, buttonHeld} !== '0) begin
            nerr++;
            $display("FAIL reset_mid_held async: got p=%b r=%b h=%b want all 0", buttonPresses, buttonReleases, buttonHeld);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            tick();
            nvec++;
            if (buttonPresses !== (j == 7 ? 4'b1000 : 4'b0000) || buttonReleases !== 4'b0000 ||
                buttonHeld !== (j >= 7 ? 4'b1000 : 4'b0000)) begin
                nerr++;
                $display("FAIL reset_mid_held edge %0d: got p=%b r=%b h=%b want p=%b", j,
                         buttonPresses, buttonReleases, buttonHeld, j == 7 ? 4'b1000 : 4'b0000);
            end
        end
        buttons = '1;
        settle(10);
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 11) == 0) buttons[i] = ~buttons[i];
            if ($urandom_range(0, 59) == 0) repeatEnable = ~repeatEnable;
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                model_clear();
                tick();
                reset = 1'b1;
            end else tick();
            nvec++;
            if (buttonPresses !== m_press || buttonReleases !== m_rel || buttonHeld !== m_held) begin
                nerr++;
                $display("FAIL random cycle %0d: got p=%b r=%b h=%b want p=%b r=%b h=%b", c,
                         buttonPresses, buttonReleases, buttonHeld, m_press, m_rel, m_held);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_auto_repeat();
        test_simultaneous();
        test_reset_mid_held();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
